// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM row-access sequencer.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    WL    = 3'd2,
    SENSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int PRE_CYC_DEF   = 1;
  localparam int WL_CYC_DEF    = 2;
  localparam int SENSE_CYC_DEF = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_access_ctrl_arb.sv
// Two-input round-robin arbiter: the pointer breaks ties and flips to the loser after a grant.
module rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       en,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       ptr_next
);

  // Grant selection and pointer update
  always_comb begin
    grant    = 2'b00;
    ptr_next = ptr;
    if (en) begin
      if (valid == 2'b11) begin
        grant = (ptr == REQ1) ? 2'b10 : 2'b01;
      end else begin
        grant = valid;
      end
    end else begin
      grant = 2'b00;
    end
    if (grant[0]) begin
      ptr_next = REQ1;
    end else if (grant[1]) begin
      ptr_next = REQ0;
    end else begin
      ptr_next = ptr;
    end
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// SRAM row-access sequencer: arbitrates two requesters, then times precharge/wordline/write/sense.
// Optional rd_cnt/wr_cnt completion counters when SRAM_ACCESS_CTRL_STATS_EN is defined.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int PRE_CYC   = PRE_CYC_DEF,
  parameter int WL_CYC    = WL_CYC_DEF,
  parameter int SENSE_CYC = SENSE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] dec_addr,
  output logic              pre_n,
  output logic              wl_en,
  output logic              wr_en,
  output logic              se,
  output logic              done_valid,
  output logic              done_id,
  output logic              done_we
`ifdef SRAM_ACCESS_CTRL_STATS_EN
  ,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
`endif
);

  localparam int CNT_W = $clog2(max3(PRE_CYC, WL_CYC, SENSE_CYC)) + 1;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             ptr_r, ptr_next_s;
  logic [1:0]       grant_s;
  logic             accept_s;

  rr_arb2 u_arb (
    .valid    ({req1_valid, req0_valid}),
    .en       (state_r == IDLE),
    .ptr      (ptr_r),
    .grant    (grant_s),
    .ptr_next (ptr_next_s)
  );

  assign req0_ready = grant_s[0];
  assign req1_ready = grant_s[1];
  assign accept_s   = |grant_s;

  // Next-state and phase counter; the counter is reloaded with length-1 on phase entry
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = PRE;
          cnt_s   = CNT_W'(PRE_CYC - 1);
        end else begin
          state_s = IDLE;
        end
      end
      PRE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = WL;
          cnt_s   = CNT_W'(WL_CYC - 1);
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      WL: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          if (done_we) begin
            state_s = DONE;
          end else begin
            state_s = SENSE;
            cnt_s   = CNT_W'(SENSE_CYC - 1);
          end
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      SENSE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = DONE;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, accept capture and control outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      ptr_r      <= REQ0;
      dec_addr   <= {ADDR_W{1'b0}};
      done_id    <= REQ0;
      done_we    <= 1'b0;
      pre_n      <= 1'b1;
      wl_en      <= 1'b0;
      wr_en      <= 1'b0;
      se         <= 1'b0;
      done_valid <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        ptr_r    <= ptr_next_s;
        dec_addr <= grant_s[1] ? req1_addr : req0_addr;
        done_id  <= grant_s[1] ? REQ1 : REQ0;
        done_we  <= grant_s[1] ? req1_we : req0_we;
      end
      pre_n      <= (state_s != PRE);
      wl_en      <= (state_s == WL);
      wr_en      <= (state_s == WL) && done_we;
      se         <= (state_s == SENSE);
      done_valid <= (state_s == DONE);
    end
  end

`ifdef SRAM_ACCESS_CTRL_STATS_EN
  // Completion counters, bumped in the DONE cycle and wrapping at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= 16'd0;
      wr_cnt <= 16'd0;
    end else if (state_r == DONE) begin
      if (done_we) begin
        wr_cnt <= wr_cnt + 16'd1;
      end else begin
        rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end
`else
  // No completion counters in this build.
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: table of single accesses plus contention, sweep and reset sequences.
module tb_sram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_we, req1_valid, req1_we;
  logic [5:0] req0_addr, req1_addr;
  logic       req0_ready, req1_ready;
  logic [5:0] dec_addr;
  logic       pre_n, wl_en, wr_en, se, done_valid, done_id, done_we;
`ifdef SRAM_ACCESS_CTRL_STATS_EN
  logic [15:0] rd_cnt, wr_cnt;
`endif

  sram_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .dec_addr(dec_addr), .pre_n(pre_n), .wl_en(wl_en), .wr_en(wr_en), .se(se),
    .done_valid(done_valid), .done_id(done_id), .done_we(done_we)
`ifdef SRAM_ACCESS_CTRL_STATS_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  logic [63:0] wl_n;

  // Behavioural registered 6-to-64 decoder, active-low wordlines
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wl_n <= '1;
    else        wl_n <= ~(64'd1 << dec_addr);
  end

  always @(negedge clk) begin
    if (done_valid) done_seen <= done_seen + 1;
  end

  // Per-offset expectations from accept cycle T (bits: pre_low, wl_en, wr_en, se, done), T+0 in LSBs
  localparam logic [29:0] RD_TR = {5'b00001, 5'b00010, 5'b01000, 5'b01000, 5'b10000, 5'b00000};
  localparam logic [29:0] WR_TR = {5'b00000, 5'b00001, 5'b01100, 5'b01100, 5'b10000, 5'b00000};

  typedef struct {
    logic        id;
    logic        we;
    logic [5:0]  addr;
    logic [29:0] trace;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic id, input logic v, input logic we, input logic [5:0] a);
    if (id) begin
      req1_valid = v; req1_we = we; req1_addr = a;
    end else begin
      req0_valid = v; req0_we = we; req0_addr = a;
    end
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_we = 1'b0; req1_we = 1'b0; req0_addr = 6'd0; req1_addr = 6'd0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic access(input logic id, input logic we, input logic [5:0] addr, input logic [29:0] tr);
    logic got;
    logic [4:0] obs;
    @(posedge clk); #1;
    drive(id, 1'b1, we, addr);
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    check("accept", 64'(got), 64'(1'b1));
    if (!got) begin
      drive(id, 1'b0, 1'b0, 6'd0);
      return;
    end
    check("other_ready", 64'(id ? req0_ready : req1_ready), 64'(1'b0));
    obs = {~pre_n, wl_en, wr_en, se, done_valid};
    check("trace_t0", 64'(obs), 64'(tr[4:0]));
    @(posedge clk); #1;
    drive(id, 1'b0, 1'b0, 6'd0);
    for (int off = 1; off < 6; off++) begin
      @(negedge clk);
      obs = {~pre_n, wl_en, wr_en, se, done_valid};
      check("trace", 64'(obs), 64'(tr[off*5 +: 5]));
      if (wl_en) begin
        check("dec_addr", 64'(dec_addr), 64'(addr));
        check("wordline_low", 64'(wl_n[addr]), 64'(1'b0));
        check("one_wordline", 64'($countones(~wl_n)), 64'(1));
      end
      if (done_valid) check("done_id_we", 64'({done_id, done_we}), 64'({id, we}));
    end
  endtask

  initial begin
    logic got, win;
    int base;

    vecs[0] = '{1'b0, 1'b0, 6'd10, RD_TR};
    vecs[1] = '{1'b1, 1'b1, 6'd63, WR_TR};
    vecs[2] = '{1'b0, 1'b1, 6'd0,  WR_TR};
    vecs[3] = '{1'b1, 1'b0, 6'd33, RD_TR};
    vecs[4] = '{1'b0, 1'b0, 6'd42, RD_TR};
    vecs[5] = '{1'b1, 1'b1, 6'd21, WR_TR};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_we = 1'b0; req1_we = 1'b0; req0_addr = 6'd0; req1_addr = 6'd0;
    #12;
    check("reset_ctrl", 64'({pre_n, wl_en, wr_en, se, done_valid, done_id, done_we}), 64'(7'b1000000));
    check("reset_dec_addr", 64'(dec_addr), 64'(6'd0));
    check("reset_ready", 64'({req1_ready, req0_ready}), 64'(2'b00));
    #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) access(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].trace);

    // Contention: both valid throughout, grants must alternate starting from requester 0
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 6'd5);
    drive(1'b1, 1'b1, 1'b0, 6'd6);
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk);
        got = req0_ready | req1_ready;
      end
      check("cont_accept", 64'(got), 64'(1'b1));
      check("cont_grant", 64'({req1_ready, req0_ready}), 64'((k % 2 == 1) ? 2'b10 : 2'b01));
      win = req1_ready;
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        @(negedge clk);
        got = done_valid;
      end
      check("cont_done", 64'(got), 64'(1'b1));
      check("cont_done_id", 64'(done_id), 64'(win));
      check("cont_dec_addr", 64'(dec_addr), 64'(win ? 6'd6 : 6'd5));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) @(negedge clk);

    // Address sweep: 64 back-to-back reads
    base = done_seen;
    for (int a = 0; a < 64; a++) access(1'b0, 1'b0, 6'(a), RD_TR);
    @(posedge clk); @(negedge clk);
    check("sweep_done_count", 64'(done_seen - base), 64'(64));

    // Mid-access reset during the wordline phase
    do_reset();
    @(posedge clk); #1 drive(1'b0, 1'b1, 1'b0, 6'd20);
    @(negedge clk);
    check("mid_accept", 64'(req0_ready), 64'(1'b1));
    @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    @(negedge clk);
    check("mid_wl_before", 64'(wl_en), 64'(1'b1));
    #1 rst_n = 1'b0;
    #1;
    check("mid_ctrl_after", 64'({pre_n, wl_en, wr_en, se, done_valid}), 64'(5'b10000));
    check("mid_dec_addr", 64'(dec_addr), 64'(6'd0));
    base = done_seen;
    @(posedge clk); #1 rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 6'd1);
    drive(1'b1, 1'b1, 1'b0, 6'd2);
    @(negedge clk);
    check("mid_ptr_idle", 64'({req1_ready, req0_ready}), 64'(2'b01));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_done_count", 64'(done_seen - base), 64'(1));

`ifdef SRAM_ACCESS_CTRL_STATS_EN
    do_reset();
    check("stats_reset", 64'({rd_cnt, wr_cnt}), 64'(32'd0));
    access(1'b0, 1'b0, 6'd3, RD_TR);
    access(1'b1, 1'b1, 6'd4, WR_TR);
    access(1'b0, 1'b0, 6'd5, RD_TR);
    access(1'b1, 1'b1, 6'd6, WR_TR);
    access(1'b0, 1'b0, 6'd7, RD_TR);
    @(posedge clk); #1;
    check("stats_rd", 64'(rd_cnt), 64'(16'd3));
    check("stats_wr", 64'(wr_cnt), 64'(16'd2));
    force dut.rd_cnt = 16'hFFFF;
    #1 release dut.rd_cnt;
    #1 check("stats_forced", 64'(rd_cnt), 64'(16'hFFFF));
    access(1'b0, 1'b0, 6'd8, RD_TR);
    @(posedge clk); #1;
    check("stats_wrap", 64'(rd_cnt), 64'(16'd0));
    check("stats_wr_hold", 64'(wr_cnt), 64'(16'd2));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
